// File: rtl/voice_allocator.sv
// voice_allocator: schedules note requests from the song reader onto a pool of
// NUM_VOICES note_player voices. Picks the lowest free voice, presents the note
// and duration one cycle after the request, and tracks per-voice occupancy.
//
// Optional feature macro: VOICE_ALLOC_STEAL_EN
//   defined   -> when every voice is busy, a non-rest note steals the voice at a
//                round-robin steal pointer instead of being dropped.
//   undefined -> when every voice is busy, a non-rest note is dropped and
//                note_dropped pulses for one cycle.
module voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  flush,
  input  logic                  new_note,
  input  logic [NOTE_W-1:0]     note_in,
  input  logic [NOTE_W-1:0]     duration_in,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] load_voice,
  output logic [NOTE_W-1:0]     note_out,
  output logic [NOTE_W-1:0]     duration_out,
  output logic [NUM_VOICES-1:0] busy,
  output logic [3:0]            active_count,
  output logic                  note_dropped
);

  // Number of set bits in a voice mask; NUM_VOICES <= 8 always fits in 4 bits.
  function automatic logic [3:0] popcount(input logic [NUM_VOICES-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  // Registered state
  logic                  run_r;          // low until the first edge after reset release
  logic [NUM_VOICES-1:0] busy_r;
  logic [NUM_VOICES-1:0] load_voice_r;
  logic [NOTE_W-1:0]     note_out_r;
  logic [NOTE_W-1:0]     duration_out_r;
  logic [3:0]            active_count_r;
  logic                  note_dropped_r;

  // Next-state / decode signals
  logic                  accept_s;       // request sampled this cycle
  logic                  note_req_s;     // accepted and not a rest
  logic [NUM_VOICES-1:0] busy_rel_s;     // occupancy after this cycle's done pulses
  logic [NUM_VOICES-1:0] free_s;
  logic                  any_free_s;
  logic [NUM_VOICES-1:0] lowest_free_s;  // one-hot lowest-index free voice
  logic [NUM_VOICES-1:0] load_sel_s;
  logic                  drop_s;
  logic [NUM_VOICES-1:0] busy_next_s;

`ifdef VOICE_ALLOC_STEAL_EN
  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  logic [PTR_W-1:0]      steal_ptr_r;
  logic [NUM_VOICES-1:0] steal_oh_s;
  logic                  steal_adv_s;
`endif

  // Request qualification and release of voices that finished this cycle.
  // voice_done only clears voices that are actually busy, and it is applied
  // before allocation so a voice freed this cycle can take this cycle's note.
  always_comb begin
    accept_s      = run_r & play & new_note & ~flush;
    note_req_s    = accept_s & (note_in != {NOTE_W{1'b0}});
    busy_rel_s    = busy_r & ~(voice_done & busy_r);
    free_s        = ~busy_rel_s;
    any_free_s    = |free_s;
    // Isolate the lowest set bit: x & -x.
    lowest_free_s = free_s & (~free_s + {{(NUM_VOICES-1){1'b0}}, 1'b1});
  end

`ifdef VOICE_ALLOC_STEAL_EN
  // Allocation with stealing: lowest free voice, else the voice at the steal pointer.
  always_comb begin
    steal_oh_s  = {{(NUM_VOICES-1){1'b0}}, 1'b1} << steal_ptr_r;
    drop_s      = 1'b0;
    steal_adv_s = 1'b0;
    if (note_req_s) begin
      if (any_free_s) begin
        load_sel_s = lowest_free_s;
      end else begin
        load_sel_s  = steal_oh_s;
        steal_adv_s = 1'b1;
      end
    end else begin
      load_sel_s = {NUM_VOICES{1'b0}};
    end
  end

  // Round-robin steal pointer; flush returns it to voice 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steal_ptr_r <= {PTR_W{1'b0}};
    end else if (flush) begin
      steal_ptr_r <= {PTR_W{1'b0}};
    end else if (steal_adv_s) begin
      if (steal_ptr_r == PTR_W'(NUM_VOICES - 1)) begin
        steal_ptr_r <= {PTR_W{1'b0}};
      end else begin
        steal_ptr_r <= steal_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      steal_ptr_r <= steal_ptr_r;
    end
  end
`else
  // Allocation without stealing: lowest free voice, else drop the note.
  always_comb begin
    if (note_req_s) begin
      if (any_free_s) begin
        load_sel_s = lowest_free_s;
        drop_s     = 1'b0;
      end else begin
        load_sel_s = {NUM_VOICES{1'b0}};
        drop_s     = 1'b1;
      end
    end else begin
      load_sel_s = {NUM_VOICES{1'b0}};
      drop_s     = 1'b0;
    end
  end
`endif

  // Occupancy update: flush empties the pool, otherwise released voices plus the new load.
  always_comb begin
    if (flush) begin
      busy_next_s = {NUM_VOICES{1'b0}};
    end else begin
      busy_next_s = busy_rel_s | load_sel_s;
    end
  end

  // Output and occupancy registers; active_count tracks popcount of busy on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r          <= 1'b0;
      busy_r         <= {NUM_VOICES{1'b0}};
      load_voice_r   <= {NUM_VOICES{1'b0}};
      note_out_r     <= {NOTE_W{1'b0}};
      duration_out_r <= {NOTE_W{1'b0}};
      active_count_r <= 4'd0;
      note_dropped_r <= 1'b0;
    end else begin
      run_r          <= 1'b1;
      busy_r         <= busy_next_s;
      load_voice_r   <= load_sel_s;
      active_count_r <= popcount(busy_next_s);
      note_dropped_r <= drop_s;
      if (|load_sel_s) begin
        note_out_r     <= note_in;
        duration_out_r <= duration_in;
      end else begin
        note_out_r     <= note_out_r;
        duration_out_r <= duration_out_r;
      end
    end
  end

  assign load_voice   = load_voice_r;
  assign note_out     = note_out_r;
  assign duration_out = duration_out_r;
  assign busy         = busy_r;
  assign active_count = active_count_r;
  assign note_dropped = note_dropped_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed table-driven bench for voice_allocator (NUM_VOICES=3, NOTE_W=6).
// Expectations adapt to the VOICE_ALLOC_STEAL_EN build option.
module tb_voice_allocator;

`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       play;
  logic       flush;
  logic       new_note;
  logic [5:0] note_in;
  logic [5:0] duration_in;
  logic [2:0] voice_done;
  logic [2:0] load_voice;
  logic [5:0] note_out;
  logic [5:0] duration_out;
  logic [2:0] busy;
  logic [3:0] active_count;
  logic       note_dropped;

  int n_cmp = 0;
  int n_bad = 0;

  voice_allocator #(.NUM_VOICES(3), .NOTE_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .flush        (flush),
    .new_note     (new_note),
    .note_in      (note_in),
    .duration_in  (duration_in),
    .voice_done   (voice_done),
    .load_voice   (load_voice),
    .note_out     (note_out),
    .duration_out (duration_out),
    .busy         (busy),
    .active_count (active_count),
    .note_dropped (note_dropped)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       play;
    logic       flush;
    logic       nn;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] done;
    logic [2:0] e_load;
    logic [5:0] e_note;
    logic [5:0] e_dur;
    logic [2:0] e_busy;
    logic [3:0] e_cnt;
    logic       e_drop;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [2:0] e_load, input logic [5:0] e_note,
                         input logic [5:0] e_dur, input logic [2:0] e_busy, input logic [3:0] e_cnt,
                         input logic e_drop);
    chk("load_voice", idx, {29'd0, load_voice}, {29'd0, e_load});
    chk("note_out", idx, {26'd0, note_out}, {26'd0, e_note});
    chk("duration_out", idx, {26'd0, duration_out}, {26'd0, e_dur});
    chk("busy", idx, {29'd0, busy}, {29'd0, e_busy});
    chk("active_count", idx, {28'd0, active_count}, {28'd0, e_cnt});
    chk("note_dropped", idx, {31'd0, note_dropped}, {31'd0, e_drop});
    chk("load_onehot", idx, ($countones(load_voice) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // Table: inputs driven before an edge, outputs expected after it.
    //               play  fl   nn   note  dur   done    load    note  dur   busy    cnt   drop
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 6'd40, 6'd3, 3'b000, 3'b000, 6'd0,  6'd0, 3'b000, 4'd0, 1'b0}; // first edge after release ignored
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 6'd12, 6'd8, 3'b000, 3'b001, 6'd12, 6'd8, 3'b001, 4'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'd0,  6'd0, 3'b000, 3'b000, 6'd12, 6'd8, 3'b001, 4'd1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 6'd0,  6'd0, 3'b000, 3'b000, 6'd12, 6'd8, 3'b000, 4'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 6'd5,  6'd1, 3'b000, 3'b001, 6'd5,  6'd1, 3'b001, 4'd1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 6'd7,  6'd2, 3'b000, 3'b010, 6'd7,  6'd2, 3'b011, 4'd2, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 6'd9,  6'd3, 3'b000, 3'b100, 6'd9,  6'd3, 3'b111, 4'd3, 1'b0};
    // Pool full: steal voice 0 (pointer 0 -> 1) or drop.
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 6'd11, 6'd4, 3'b000,
                 STEAL ? 3'b001 : 3'b000, STEAL ? 6'd11 : 6'd9, STEAL ? 6'd4 : 6'd3,
                 3'b111, 4'd3, STEAL ? 1'b0 : 1'b1};
    // Second overflow: steal voice 1 (pointer 1 -> 2) or drop.
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 6'd13, 6'd5, 3'b000,
                 STEAL ? 3'b010 : 3'b000, STEAL ? 6'd13 : 6'd9, STEAL ? 6'd5 : 6'd3,
                 3'b111, 4'd3, STEAL ? 1'b0 : 1'b1};
    // Voice 1 done and new note in the same cycle: voice 1 reused immediately.
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 6'd20, 6'd6, 3'b010, 3'b010, 6'd20, 6'd6, 3'b111, 4'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6'd0,  6'd0, 3'b001, 3'b000, 6'd20, 6'd6, 3'b110, 4'd2, 1'b0};
    // Rest note: accepted, no load, no busy change.
    vecs[11] = '{1'b1, 1'b0, 1'b1, 6'd0,  6'd7, 3'b000, 3'b000, 6'd20, 6'd6, 3'b110, 4'd2, 1'b0};
    // play=0 gates the request.
    vecs[12] = '{1'b0, 1'b0, 1'b1, 6'd15, 6'd9, 3'b000, 3'b000, 6'd20, 6'd6, 3'b110, 4'd2, 1'b0};
    // voice_done on an idle voice is ignored.
    vecs[13] = '{1'b1, 1'b0, 1'b0, 6'd0,  6'd0, 3'b001, 3'b000, 6'd20, 6'd6, 3'b110, 4'd2, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 6'd15, 6'd9, 3'b000, 3'b001, 6'd15, 6'd9, 3'b111, 4'd3, 1'b0};
    // Flush with a coincident request: pool emptied, request suppressed.
    vecs[15] = '{1'b1, 1'b1, 1'b1, 6'd30, 6'd1, 3'b000, 3'b000, 6'd15, 6'd9, 3'b000, 4'd0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 6'd33, 6'd2, 3'b000, 3'b001, 6'd33, 6'd2, 3'b001, 4'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 6'd1,  6'd2, 3'b000, 3'b010, 6'd1,  6'd2, 3'b011, 4'd2, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 6'd2,  6'd3, 3'b000, 3'b100, 6'd2,  6'd3, 3'b111, 4'd3, 1'b0};
    // Overflow after flush: steal pointer was reset, so voice 0 is stolen.
    vecs[19] = '{1'b1, 1'b0, 1'b1, 6'd3,  6'd4, 3'b000,
                 STEAL ? 3'b001 : 3'b000, STEAL ? 6'd3 : 6'd2, STEAL ? 6'd4 : 6'd3,
                 3'b111, 4'd3, STEAL ? 1'b0 : 1'b1};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 6'd0,  6'd0, 3'b101, 3'b000, STEAL ? 6'd3 : 6'd2,
                 STEAL ? 6'd4 : 6'd3, 3'b000, 4'd0, 1'b0};

    // Reset asserted from time 0.
    reset       = 1'b0;
    play        = 1'b0;
    flush       = 1'b0;
    new_note    = 1'b0;
    note_in     = 6'd0;
    duration_in = 6'd0;
    voice_done  = 3'b000;
    #1;
    chk_all(-1, 3'b000, 6'd0, 6'd0, 3'b000, 4'd0, 1'b0);

    // Release between edges so the next rising edge is the first one after release.
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      play        = vecs[i].play;
      flush       = vecs[i].flush;
      new_note    = vecs[i].nn;
      note_in     = vecs[i].note;
      duration_in = vecs[i].dur;
      voice_done  = vecs[i].done;
      @(posedge clk);
      #1;
      chk_all(i, vecs[i].e_load, vecs[i].e_note, vecs[i].e_dur, vecs[i].e_busy,
              vecs[i].e_cnt, vecs[i].e_drop);
    end

    // Asynchronous reset while a load pulse is on the outputs.
    @(negedge clk);
    play        = 1'b1;
    flush       = 1'b0;
    new_note    = 1'b1;
    note_in     = 6'd44;
    duration_in = 6'd5;
    voice_done  = 3'b000;
    @(posedge clk);
    #1;
    chk_all(100, 3'b001, 6'd44, 6'd5, 3'b001, 4'd1, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk_all(101, 3'b000, 6'd0, 6'd0, 3'b000, 4'd0, 1'b0);

    // Requests are ignored across edges while reset is held.
    @(negedge clk);
    note_in = 6'd50;
    @(posedge clk);
    #1;
    chk_all(102, 3'b000, 6'd0, 6'd0, 3'b000, 4'd0, 1'b0);

    // Release, then a normal request loads voice 0 again.
    #2 reset = 1'b1;
    @(negedge clk);
    new_note = 1'b0;
    @(negedge clk);
    new_note    = 1'b1;
    note_in     = 6'd12;
    duration_in = 6'd8;
    @(posedge clk);
    #1;
    chk_all(103, 3'b001, 6'd12, 6'd8, 3'b001, 4'd1, 1'b0);
    @(negedge clk);
    new_note = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL provide parameter NUM_VOICES, default 3, number of note_player voices scheduled (legal 2..8).
REQ-002 SHALL provide parameter NOTE_W, default 6, width of note and duration fields.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port play  input  1  allocation enable from the master control unit.
REQ-006 SHALL have port flush  input  1  single-cycle pulse, releases all voices (song change/reset_player).
REQ-007 SHALL have port new_note  input  1  single-cycle request from song reader.
REQ-008 SHALL have ports note_in and duration_in  input  NOTE_W each  values qualified by new_note.
REQ-009 SHALL have port voice_done  input  NUM_VOICES  per-voice single-cycle done pulse from each note_player.
REQ-010 SHALL have port load_voice  output  NUM_VOICES  one-hot load pulse to the selected voice.
REQ-011 SHALL have ports note_out and duration_out  output  NOTE_W each  registered values shared by all voices.
REQ-012 SHALL have port busy  output  NUM_VOICES  per-voice occupied flag.
REQ-013 SHALL have port active_count  output  4  number of busy voices.
REQ-014 SHALL have port note_dropped  output  1  single-cycle pulse when a request is discarded.

Function
REQ-015 SHALL sample new_note only when play=1; new_note with play=0 is ignored with no output pulse.
REQ-016 SHALL apply voice_done before allocation in the same cycle, so a voice freed in cycle N is eligible for a request in cycle N.
REQ-017 SHALL select the lowest-index non-busy voice for an accepted note.
REQ-018 SHALL assert load_voice, note_out, duration_out exactly one cycle after new_note (latency 1), load_voice high for one cycle only.
REQ-019 SHALL set busy[i] on the same edge load_voice[i] is asserted and clear it on the edge following voice_done[i].
REQ-020 SHALL treat note_in=0 (rest) as accepted without loading a voice: no load_voice, no busy change, no note_dropped.
REQ-021 SHALL hold note_out/duration_out at last loaded values when no load occurs.
REQ-022 SHALL ignore voice_done[i] when busy[i]=0.
REQ-023 SHALL, on flush, clear all busy bits next edge, suppress any load from a new_note in the same cycle, and reset the steal pointer to 0.
REQ-024 SHALL keep active_count equal to popcount(busy) every cycle.
REQ-025 SHALL never assert more than one load_voice bit in a cycle.

Reset
REQ-026 SHALL, while reset=0, force load_voice=0, busy=0, active_count=0, note_out=0, duration_out=0, note_dropped=0, steal pointer=0, independent of clk.
REQ-027 SHALL resume normal operation on the first rising clk edge after reset returns to 1; a new_note coincident with that edge is ignored.

Configuration
REQ-028 SHALL compile voice stealing in only when macro VOICE_ALLOC_STEAL_EN is defined.
REQ-029 With VOICE_ALLOC_STEAL_EN: all voices busy and new non-rest note -> load voice at steal pointer (busy stays 1), then advance pointer modulo NUM_VOICES; note_dropped stays 0.
REQ-030 Without VOICE_ALLOC_STEAL_EN: all voices busy and new non-rest note -> no load, note_dropped pulses 1 cycle one cycle after new_note; no steal pointer logic present.

Verification
REQ-031 Reset/idle: reset=0 mid-load -> all outputs 0 immediately; release, new_note note_in=12 dur=8 -> load_voice=001, note_out=12, duration_out=8 next cycle, busy=001, active_count=1.
REQ-032 Fill: three new_notes 5,7,9 on consecutive cycles -> load_voice 001,010,100 in order; active_count=3.
REQ-033 Full: fourth note 11 with all busy -> steal build: load_voice=001 then pointer=1, next overflow load_voice=010; non-steal build: note_dropped=1, load_voice=000.
REQ-034 Simultaneous: all busy, voice_done=010 and new_note note 20 same cycle -> load_voice=010, note_out=20, busy stays 111, note_dropped=0.
REQ-035 Rest/play gating: note_in=0 -> no load, busy unchanged; play=0 with note 15 -> no load, no drop.
REQ-036 Flush: busy=111, flush with new_note same cycle -> busy=000, active_count=0, load_voice=000 next cycle.
